// File: rtl/sbn_pkg.sv
// sbn_pkg -- shared definitions for the SBN (subtract-and-branch-if-negative) core.
//   * sbn_state_e : FSM state encodings, also exported on the monitor 'state' tap
//   * FLD_A..FLD_D: index of each operand field inside the packed instruction
//                   word {A,B,C,D} (A most significant)
//   * HALT_ADDR   : all-ones C field marks a halt instruction; slice it down to
//                   the configured field width (fields up to FIELD_MAX bits)
package sbn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LDA   = 3'd2,
        ST_LDB   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5
    } sbn_state_e;

    // Field positions within a [3:0][FWIDTH-1:0] packed instruction word
    localparam logic [1:0] FLD_A = 2'd3;
    localparam logic [1:0] FLD_B = 2'd2;
    localparam logic [1:0] FLD_C = 2'd1;
    localparam logic [1:0] FLD_D = 2'd0;

    localparam int unsigned FIELD_MAX = 32'd16;
    localparam logic [FIELD_MAX-1:0] HALT_ADDR = 16'hFFFF;

endpackage

// File: rtl/sbn_if.sv
// sbn_if -- control, loader, debug and monitor signals of sbn_core.
//   master: start/abort/start_pc, imem/dmem loader ports, dbg_addr (driven)
//           dbg_rdata, busy, halted, state, pc, a, b, halt_value, icount, ovf (observed)
//   slave : the same signals seen from the core side
interface sbn_if #(
    parameter int FWIDTH = 8,
    parameter int DWIDTH = 32
);
    logic                  start;
    logic                  abort;
    logic [FWIDTH-1:0]     start_pc;
    logic                  imem_we;
    logic [FWIDTH-1:0]     imem_addr;
    logic [4*FWIDTH-1:0]   imem_wdata;
    logic                  dmem_we;
    logic [FWIDTH-1:0]     dmem_addr;
    logic [DWIDTH-1:0]     dmem_wdata;
    logic [FWIDTH-1:0]     dbg_addr;
    logic [DWIDTH-1:0]     dbg_rdata;
    logic                  busy;
    logic                  halted;
    logic [2:0]            state;
    logic [FWIDTH-1:0]     pc;
    logic [DWIDTH-1:0]     a;
    logic [DWIDTH-1:0]     b;
    logic [DWIDTH-1:0]     halt_value;
    logic [31:0]           icount;
    logic                  ovf;

    modport master (
        output start, abort, start_pc, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata, dbg_addr,
        input  dbg_rdata, busy, halted, state, pc, a, b, halt_value, icount, ovf
    );

    modport slave (
        input  start, abort, start_pc, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata, dbg_addr,
        output dbg_rdata, busy, halted, state, pc, a, b, halt_value, icount, ovf
    );
endinterface

// File: rtl/sbn_alu.sv
// sbn_alu -- combinational X-Y subtractor for the SBN core.
//   x, y : two's-complement operands
//   diff : x - y, wrapped to DWIDTH bits
//   neg  : sign bit of the wrapped result (branch condition)
//   ovf  : signed overflow of the subtraction
module sbn_alu #(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] x,
    input  logic [DWIDTH-1:0] y,
    output logic [DWIDTH-1:0] diff,
    output logic              neg,
    output logic              ovf
);
    assign diff = x - y;
    assign neg  = diff[DWIDTH-1];
    // Overflow only when operand signs differ and the result sign differs from x
    assign ovf  = (x[DWIDTH-1] ^ y[DWIDTH-1]) & (diff[DWIDTH-1] ^ x[DWIDTH-1]);
endmodule

// File: rtl/sbn_core.sv
// sbn_core -- one-instruction (subtract and branch if negative) processor.
// Instruction {A,B,C,D}: dmem[C] <= dmem[A]-dmem[B]; PC <= D if negative else PC+1.
// C == all ones halts with halt_value = dmem[A]-dmem[B] and no write.
// Ports: clk, rst (async, active high), bus (sbn_if.slave: start/abort/start_pc,
//        imem/dmem loader, dbg read, busy/halted/state/pc/a/b/halt_value/icount/ovf).
// Optional feature: define SBN_OVF_HALT_EN to halt (ovf=1, no write) on signed
//        overflow in write-back; otherwise the wrapped result is written and ovf=0.
module sbn_core
    import sbn_pkg::*;
#(
    parameter int FWIDTH = 8,
    parameter int DWIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    sbn_if.slave bus
);
    localparam int DEPTH = 2 ** FWIDTH;
    typedef logic [3:0][FWIDTH-1:0] insn_t;

    insn_t             imem_r [DEPTH];
    logic [DWIDTH-1:0] dmem_r [DEPTH];

    sbn_state_e        state_r;
    logic [FWIDTH-1:0] pc_r;
    insn_t             ir_r;
    logic [DWIDTH-1:0] x_r;
    logic [DWIDTH-1:0] y_r;
    logic [DWIDTH-1:0] halt_value_r;
    logic [31:0]       icount_r;
    logic              ovf_r;
    logic              busy_r;
    logic              halted_r;

    logic [DWIDTH-1:0] alu_y_s;
    logic [DWIDTH-1:0] diff_s;
    logic              neg_s;
    logic              alu_ovf_s;
    logic              ovf_hit_s;
    logic              imem_we_s;
    logic              dmem_we_s;
    logic [FWIDTH-1:0] dmem_waddr_s;
    logic [DWIDTH-1:0] dmem_wdata_s;

    // In LDB the halt value must use the word being loaded into Y, not the stale Y
    always_comb begin
        if (state_r == ST_LDB) begin
            alu_y_s = dmem_r[ir_r[FLD_B]];
        end else begin
            alu_y_s = y_r;
        end
    end

    sbn_alu #(.DWIDTH(DWIDTH)) u_alu (
        .x    (x_r),
        .y    (alu_y_s),
        .diff (diff_s),
        .neg  (neg_s),
        .ovf  (alu_ovf_s)
    );

`ifdef SBN_OVF_HALT_EN
    assign ovf_hit_s = alu_ovf_s;
`else
    logic unused_alu_ovf_s;
    assign ovf_hit_s        = 1'b0;
    assign unused_alu_ovf_s = alu_ovf_s;
`endif

    // Loader ports only act while the core is not executing; reset blocks all writes
    assign imem_we_s = bus.imem_we && !busy_r && !rst;

    // Data memory write port: result write-back in WB, otherwise the loader
    always_comb begin
        dmem_we_s    = 1'b0;
        dmem_waddr_s = bus.dmem_addr;
        dmem_wdata_s = bus.dmem_wdata;
        if (rst) begin
            dmem_we_s = 1'b0;
        end else if (state_r == ST_WB) begin
            if (!bus.abort && !ovf_hit_s) begin
                dmem_we_s    = 1'b1;
                dmem_waddr_s = ir_r[FLD_C];
                dmem_wdata_s = diff_s;
            end else begin
                dmem_we_s = 1'b0;
            end
        end else if (!busy_r && bus.dmem_we) begin
            dmem_we_s = 1'b1;
        end else begin
            dmem_we_s = 1'b0;
        end
    end

    // Synchronous memory writes (contents are intentionally not reset)
    always_ff @(posedge clk) begin
        if (imem_we_s) begin
            imem_r[bus.imem_addr] <= bus.imem_wdata;
        end
        if (dmem_we_s) begin
            dmem_r[dmem_waddr_s] <= dmem_wdata_s;
        end
    end

    // Control FSM with datapath registers and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pc_r         <= {FWIDTH{1'b0}};
            ir_r         <= {(4*FWIDTH){1'b0}};
            x_r          <= {DWIDTH{1'b0}};
            y_r          <= {DWIDTH{1'b0}};
            halt_value_r <= {DWIDTH{1'b0}};
            icount_r     <= 32'd0;
            ovf_r        <= 1'b0;
            busy_r       <= 1'b0;
            halted_r     <= 1'b0;
        end else if (bus.abort && state_r != ST_IDLE) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    // abort in IDLE takes priority over start
                    if (bus.start && !bus.abort) begin
                        state_r  <= ST_FETCH;
                        pc_r     <= bus.start_pc;
                        ovf_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        halted_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    ir_r    <= imem_r[pc_r];
                    state_r <= ST_LDA;
                end
                ST_LDA: begin
                    x_r     <= dmem_r[ir_r[FLD_A]];
                    state_r <= ST_LDB;
                end
                ST_LDB: begin
                    y_r <= alu_y_s;
                    if (ir_r[FLD_C] == HALT_ADDR[FWIDTH-1:0]) begin
                        halt_value_r <= diff_s;
                        state_r      <= ST_HALT;
                        busy_r       <= 1'b0;
                        halted_r     <= 1'b1;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (ovf_hit_s) begin
                        halt_value_r <= diff_s;
                        ovf_r        <= 1'b1;
                        state_r      <= ST_HALT;
                        busy_r       <= 1'b0;
                        halted_r     <= 1'b1;
                    end else begin
                        pc_r     <= neg_s ? ir_r[FLD_D] : pc_r + {{(FWIDTH-1){1'b0}}, 1'b1};
                        icount_r <= icount_r + 32'd1;
                        state_r  <= ST_FETCH;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dbg_rdata  = dmem_r[bus.dbg_addr];
    assign bus.busy       = busy_r;
    assign bus.halted     = halted_r;
    assign bus.state      = state_r;
    assign bus.pc         = pc_r;
    assign bus.a          = x_r;
    assign bus.b          = y_r;
    assign bus.halt_value = halt_value_r;
    assign bus.icount     = icount_r;
    assign bus.ovf        = ovf_r;

endmodule
